// File: rtl/psram_qspi_ctrl.sv
// psram_qspi_ctrl: QPI/SPI PSRAM burst controller; define PSRAM_LED_STATUS_EN for status LEDs
module psram_qspi_ctrl #(
  parameter int ADDR_W      = 23,
  parameter int LANES       = 4,
  parameter int BURST_LEN   = 4,
  parameter int INIT_CYCLES = 4096,
  parameter int RD_WAIT     = 6
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [ADDR_W-1:0]      req_addr,
  input  logic [8*BURST_LEN-1:0] req_wdata,
  output logic [8*BURST_LEN-1:0] rd_data,
  output logic                   done,
  output logic                   psram_clk,
  output logic                   psram_cs_n,
  output logic [3:0]             psram_dq_o,
  output logic [3:0]             psram_dq_oe,
  input  logic [3:0]             psram_dq_i,
  output logic [5:0]             led
);
  localparam int DW = 8*BURST_LEN;
  localparam int TW = 32 + DW;
  localparam int CW = 32;
  localparam logic [CW-1:0] INIT_N = CW'(INIT_CYCLES - 1);
  localparam logic [CW-1:0] CMD_N  = CW'(8/LANES - 1);
  localparam logic [CW-1:0] ADDR_N = CW'(24/LANES - 1);
  localparam logic [CW-1:0] DATA_N = CW'(DW/LANES - 1);
  localparam logic [CW-1:0] WAIT_N = CW'(RD_WAIT - 1);

  if (LANES != 1 && LANES != 4) begin : g_lanes_chk
    $error("psram_qspi_ctrl: LANES must be 1 or 4");
  end

  typedef enum logic [3:0] {INIT_WAIT, QPI_ENTER, IDLE, CMD, ADDR, WAIT, WDATA, RDATA, DESEL} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            sclk_q, sclk_d;
  logic [TW-1:0]   sh_q, sh_d;
  logic [DW-1:0]   rx_q, rx_d;
  logic [DW-1:0]   rd_q, rd_d;
  logic            done_q, done_d;
  logic            wr_q, wr_d;
  logic            txn_q, txn_d;
  logic [DW-1:0]   wswap, rswap;
  logic [7:0]      cmd;
  logic [3:0]      din;
  logic            active, tx, fall, last;

  for (genvar i = 0; i < BURST_LEN; i++) begin : g_swap
    assign wswap[8*i +: 8] = req_wdata[8*(BURST_LEN-1-i) +: 8];
    assign rswap[8*i +: 8] = rx_q[8*(BURST_LEN-1-i) +: 8];
  end

  assign active = state_q inside {QPI_ENTER, CMD, ADDR, WAIT, WDATA, RDATA};
  assign tx     = state_q inside {CMD, ADDR, WDATA};
  assign fall   = active && sclk_q;
  assign last   = fall && cnt_q == '0;
  assign din    = LANES == 4 ? psram_dq_i : {3'b0, psram_dq_i[1]};
  assign cmd    = LANES == 4 ? (req_write ? 8'h38 : 8'hEB) : (req_write ? 8'h02 : 8'h03);

  assign req_ready   = state_q == IDLE;
  assign psram_cs_n  = !active;
  assign psram_clk   = sclk_q;
  assign done        = done_q;
  assign rd_data     = rd_q;
  assign psram_dq_oe = state_q == QPI_ENTER ? 4'b0001 : tx ? (LANES == 4 ? 4'hF : 4'b0001) : 4'b0000;
  assign psram_dq_o  = (state_q == QPI_ENTER || (tx && LANES == 1)) ? {3'b0, sh_q[TW-1]} :
                       tx ? sh_q[TW-1 -: 4] : 4'b0000;

  // state register; reset forces chip deselect and reruns the init sequence
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT_WAIT;
      cnt_q   <= '0;
      sclk_q  <= 1'b0;
      sh_q    <= '0;
      rx_q    <= '0;
      rd_q    <= '0;
      done_q  <= 1'b0;
      wr_q    <= 1'b0;
      txn_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sclk_q  <= sclk_d;
      sh_q    <= sh_d;
      rx_q    <= rx_d;
      rd_q    <= rd_d;
      done_q  <= done_d;
      wr_q    <= wr_d;
      txn_q   <= txn_d;
    end
  end

  // next state: bits shift out on SCLK falls, sample on SCLK rises, phases end on the last fall
  always_comb begin
    state_d = state_q;
    cnt_d   = (fall && cnt_q != '0) ? cnt_q - 1 : cnt_q;
    sclk_d  = active ? ~sclk_q : 1'b0;
    sh_d    = fall ? sh_q << (state_q == QPI_ENTER ? 1 : LANES) : sh_q;
    rx_d    = (state_q == RDATA && !sclk_q) ? (rx_q << LANES) | DW'(din) : rx_q;
    rd_d    = rd_q;
    done_d  = 1'b0;
    wr_d    = wr_q;
    txn_d   = txn_q;
    case (state_q)
      INIT_WAIT: begin
        if (cnt_q == INIT_N) begin
          state_d = LANES == 4 ? QPI_ENTER : IDLE;
          cnt_d   = LANES == 4 ? CW'(7) : '0;
          sh_d    = {8'h35, {(TW-8){1'b0}}};
        end else begin
          cnt_d = cnt_q + 1;
        end
      end
      QPI_ENTER: if (last) begin
        state_d = DESEL;
        cnt_d   = CW'(1);
      end
      IDLE: if (req_valid) begin
        state_d = CMD;
        cnt_d   = CMD_N;
        sh_d    = {cmd, 24'(req_addr), wswap};
        wr_d    = req_write;
        txn_d   = 1'b1;
      end
      CMD: if (last) begin
        state_d = ADDR;
        cnt_d   = ADDR_N;
      end
      ADDR: if (last) begin
        state_d = wr_q ? WDATA : (LANES == 4 ? WAIT : RDATA);
        cnt_d   = (!wr_q && LANES == 4) ? WAIT_N : DATA_N;
      end
      WAIT: if (last) begin
        state_d = RDATA;
        cnt_d   = DATA_N;
      end
      WDATA, RDATA: if (last) begin
        state_d = DESEL;
        cnt_d   = CW'(1);
      end
      DESEL: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          done_d  = txn_q;
          txn_d   = 1'b0;
          rd_d    = (txn_q && !wr_q) ? rswap : rd_q;
        end else begin
          cnt_d = cnt_q - 1;
        end
      end
      default: state_d = INIT_WAIT;
    endcase
  end

`ifdef PSRAM_LED_STATUS_EN
  logic [5:0] led_q;
  logic [1:0] dcnt_q;
  assign led = led_q;
  // status LEDs are registered so they read all-off while reset is held
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q  <= 6'h3F;
      dcnt_q <= 2'b00;
    end else begin
      dcnt_q <= dcnt_q + 2'(done_q);
      led_q  <= ~{dcnt_q, txn_q && !wr_q, txn_q && wr_q,
                  state_q == INIT_WAIT || state_q == QPI_ENTER, state_q == IDLE};
    end
  end
`else
  assign led = 6'h3F;
`endif
endmodule

// File: tb/tb_psram_qspi_ctrl.sv
// tb_psram_qspi_ctrl: scoreboard bench for a QPI burst-4 and an SPI burst-1 controller
`timescale 1ns/1ps
module tb_psram_qspi_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct { int sclk; int noe; logic [127:0] v; } frame_t;
  frame_t      fq_a[$], fq_b[$];
  logic [31:0] dq_a[$], dq_b[$];

  logic        rst_a = 1'b1, va = 1'b0, wr_a = 1'b0, rdy_a, done_a, pclk_a, cs_a;
  logic [22:0] addr_a = '0;
  logic [31:0] wd_a = '0, rd_a;
  logic [3:0]  dqo_a, dqoe_a, dqi_a = 4'h0;
  logic [5:0]  led_a;

  logic        rst_b = 1'b1, vb = 1'b0, wr_b = 1'b0, rdy_b, done_b, pclk_b, cs_b;
  logic [22:0] addr_b = '0;
  logic [7:0]  wd_b = '0, rd_b;
  logic [3:0]  dqo_b, dqoe_b, dqi_b = 4'h0;
  logic [5:0]  led_b;

  psram_qspi_ctrl #(.ADDR_W(23), .LANES(4), .BURST_LEN(4), .INIT_CYCLES(16), .RD_WAIT(6)) u_a (
    .clk(clk), .rst_n(rst_a), .req_valid(va), .req_ready(rdy_a), .req_write(wr_a),
    .req_addr(addr_a), .req_wdata(wd_a), .rd_data(rd_a), .done(done_a),
    .psram_clk(pclk_a), .psram_cs_n(cs_a), .psram_dq_o(dqo_a), .psram_dq_oe(dqoe_a),
    .psram_dq_i(dqi_a), .led(led_a));

  psram_qspi_ctrl #(.ADDR_W(23), .LANES(1), .BURST_LEN(1), .INIT_CYCLES(16), .RD_WAIT(6)) u_b (
    .clk(clk), .rst_n(rst_b), .req_valid(vb), .req_ready(rdy_b), .req_write(wr_b),
    .req_addr(addr_b), .req_wdata(wd_b), .rd_data(rd_b), .done(done_b),
    .psram_clk(pclk_b), .psram_cs_n(cs_b), .psram_dq_o(dqo_b), .psram_dq_oe(dqoe_b),
    .psram_dq_i(dqi_b), .led(led_b));

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // chip model A: returns 11,22,33,44 after 8 command/address and 6 wait SCLK
  logic [7:0] rdb_a [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  int nf_a, ka;
  always @(negedge cs_a) begin nf_a = 0; dqi_a = 4'h0; end
  always @(negedge pclk_a) if (cs_a === 1'b0) begin
    nf_a++;
    if (nf_a >= 14 && nf_a < 22) begin
      ka = nf_a - 14;
      dqi_a = ka % 2 == 0 ? rdb_a[ka/2][7:4] : rdb_a[ka/2][3:0];
    end
  end

  // chip model B: returns 0xA5 on dq[1] after 32 command/address SCLK
  logic [7:0] rb_b = 8'hA5;
  int nf_b;
  always @(negedge cs_b) begin nf_b = 0; dqi_b = 4'h0; end
  always @(negedge pclk_b) if (cs_b === 1'b0) begin
    nf_b++;
    if (nf_b >= 32 && nf_b < 40) dqi_b = {2'b00, rb_b[7-(nf_b-32)], 1'b0};
  end

  // frame capture and compare
  int ns_a, no_a, ns_b, no_b;
  logic [127:0] cv_a, cv_b;
  always @(negedge cs_a) begin ns_a = 0; no_a = 0; cv_a = '0; end
  always @(posedge pclk_a) if (cs_a === 1'b0) begin
    ns_a++;
    if (dqoe_a != 4'h0) begin no_a++; cv_a = {cv_a[123:0], dqo_a}; end
  end
  always @(posedge cs_a) if (rst_a) begin
    if (fq_a.size() == 0) fail("a_frame unexpected");
    else begin
      frame_t e;
      e = fq_a.pop_front();
      chk("a_sclk", 128'(ns_a), 128'(e.sclk));
      chk("a_noe", 128'(no_a), 128'(e.noe));
      chk("a_bits", cv_a, e.v);
    end
  end

  always @(negedge cs_b) begin ns_b = 0; no_b = 0; cv_b = '0; end
  always @(posedge pclk_b) if (cs_b === 1'b0) begin
    ns_b++;
    if (dqoe_b != 4'h0) begin no_b++; cv_b = {cv_b[126:0], dqo_b[0]}; end
  end
  always @(posedge cs_b) if (rst_b) begin
    if (fq_b.size() == 0) fail("b_frame unexpected");
    else begin
      frame_t e;
      e = fq_b.pop_front();
      chk("b_sclk", 128'(ns_b), 128'(e.sclk));
      chk("b_noe", 128'(no_b), 128'(e.noe));
      chk("b_bits", cv_b, e.v);
    end
  end

  // done monitors
  always @(negedge clk) if (done_a === 1'b1) begin
    if (dq_a.size() == 0) fail("a_done unexpected");
    else chk("a_rd_data", 128'(rd_a), 128'(dq_a.pop_front()));
    @(negedge clk);
    chk("a_done_pulse", 128'(done_a), 128'(0));
  end
  always @(negedge clk) if (done_b === 1'b1) begin
    if (dq_b.size() == 0) fail("b_done unexpected");
    else chk("b_rd_data", 128'(rd_b), 128'(dq_b.pop_front()));
    @(negedge clk);
    chk("b_done_pulse", 128'(done_b), 128'(0));
  end

  task automatic push_a(input logic [127:0] ev, input int enoe, input int esclk);
    frame_t f;
    f.sclk = esclk; f.noe = enoe; f.v = ev;
    fq_a.push_back(f);
  endtask

  task automatic push_b(input logic [127:0] ev, input int enoe, input int esclk);
    frame_t f;
    f.sclk = esclk; f.noe = enoe; f.v = ev;
    fq_b.push_back(f);
  endtask

  task automatic wait_rdy_a();
    int t = 0;
    @(negedge clk);
    while (!rdy_a && t < 300) begin @(negedge clk); t++; end
    if (!rdy_a) fail("a_ready timeout");
  endtask

  task automatic wait_done_a();
    int t = 0;
    while (!done_a && t < 300) begin @(negedge clk); t++; end
    if (!done_a) fail("a_done timeout");
  endtask

  task automatic req_a(input bit w, input logic [22:0] ad, input logic [31:0] wd,
                       input logic [127:0] ev, input int enoe, input int esclk, input logic [31:0] erd);
    push_a(ev, enoe, esclk);
    dq_a.push_back(erd);
    wait_rdy_a();
    wr_a = w; addr_a = ad; wd_a = wd; va = 1'b1;
    @(negedge clk);
    va = 1'b0;
    wait_done_a();
  endtask

  task automatic req_b(input bit w, input logic [22:0] ad, input logic [7:0] wd,
                       input logic [127:0] ev, input int enoe, input int esclk, input logic [31:0] erd);
    int t = 0;
    push_b(ev, enoe, esclk);
    dq_b.push_back(erd);
    @(negedge clk);
    while (!rdy_b && t < 300) begin @(negedge clk); t++; end
    if (!rdy_b) fail("b_ready timeout");
    wr_b = w; addr_b = ad; wd_b = wd; vb = 1'b1;
    @(negedge clk);
    vb = 1'b0;
    t = 0;
    while (!done_b && t < 300) begin @(negedge clk); t++; end
    if (!done_b) fail("b_done timeout");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    #2 rst_a = 1'b0; rst_b = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cs_n", 128'(cs_a), 128'(1));
    chk("rst_psram_clk", 128'(pclk_a), 128'(0));
    chk("rst_dq_oe", 128'(dqoe_a), 128'(0));
    chk("rst_dq_o", 128'(dqo_a), 128'(0));
    chk("rst_req_ready", 128'(rdy_a), 128'(0));
    chk("rst_done", 128'(done_a), 128'(0));
    chk("rst_rd_data", 128'(rd_a), 128'(0));
    chk("rst_led", 128'(led_a), 128'(6'h3F));
    chk("rst_b_cs_n", 128'(cs_b), 128'(1));
    push_a(128'h00110101, 8, 8);
    rst_a = 1'b1; rst_b = 1'b1;
    repeat (5) @(negedge clk);
    chk("init_not_ready", 128'(rdy_a), 128'(0));
    req_a(1'b1, 23'h000123, 32'hDDCCBBAA, 128'h38000123AABBCCDD, 16, 16, 32'h0);
    req_a(1'b0, 23'h000123, 32'h0, 128'hEB000123, 8, 22, 32'h44332211);
    req_a(1'b1, 23'h7FFFFE, 32'h12345678, 128'h387FFFFE78563412, 16, 16, 32'h44332211);
    push_a(128'hEB0003FE, 8, 22);
    dq_a.push_back(32'h44332211);
    wait_rdy_a();
    wr_a = 1'b0; addr_a = 23'h0003FE; va = 1'b1; acc = 1;
    begin
      int t = 0;
      @(negedge clk);
      while (!done_a && t < 300) begin
        if (rdy_a) acc++;
        @(negedge clk);
        t++;
      end
      va = 1'b0;
      if (!done_a) fail("a_held_valid done timeout");
    end
    chk("held_valid_accepts", 128'(acc), 128'(1));
    chk("ready_with_done", 128'(rdy_a), 128'(1));
    req_a(1'b0, 23'h0003FE, 32'h0, 128'hEB0003FE, 8, 22, 32'h44332211);
    wait_rdy_a();
    wr_a = 1'b1; addr_a = 23'h000055; wd_a = 32'h01020304; va = 1'b1;
    @(negedge clk);
    va = 1'b0;
    repeat (8) @(negedge clk);
    chk("mid_addr_cs_low", 128'(cs_a), 128'(0));
    rst_a = 1'b0;
    #1;
    chk("abort_cs_n", 128'(cs_a), 128'(1));
    chk("abort_psram_clk", 128'(pclk_a), 128'(0));
    chk("abort_dq_oe", 128'(dqoe_a), 128'(0));
    push_a(128'h00110101, 8, 8);
    repeat (3) @(negedge clk);
    rst_a = 1'b1;
    req_a(1'b0, 23'h000123, 32'h0, 128'hEB000123, 8, 22, 32'h44332211);
    req_b(1'b0, 23'h000123, 8'h00, 128'h03000123, 32, 40, 32'hA5);
    req_b(1'b1, 23'h000456, 8'h5A, 128'h020004565A, 40, 40, 32'hA5);
    repeat (10) @(negedge clk);
    chk("a_frames_left", 128'(fq_a.size()), 128'(0));
    chk("a_dones_left", 128'(dq_a.size()), 128'(0));
    chk("b_frames_left", 128'(fq_b.size()), 128'(0));
    chk("b_dones_left", 128'(dq_b.size()), 128'(0));
    chk("led_idle", 128'(led_a), 128'(6'h3F));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
